// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit
// ----------------------------------------------------------------------------
// Instruction fetch stage that sits directly in front of the IF/ID register.
// It owns the fetch PC and issues in-order requests to instruction memory
// using a request/grant/response handshake. Up to FIFO_DEPTH entries may be
// in flight or fetched-but-not-consumed. The oldest entry is presented
// downstream as {pc, inst, valid}.
//
// A branch redirect flushes the queue. Any responses still owed for
// already-issued requests are counted in drop_cnt and discarded when they
// return. Because of this, stale instructions can never reach IF/ID.
//
// Ports:
//   clk              clock, rising-edge active
//   rst              asynchronous active-high reset
//   stall_i          IF/ID cannot accept this cycle; head entry is held
//   branch_flag_i    one-cycle redirect request from ID
//   branch_target_i  redirect target (low two bits ignored)
//   inst_req_o       memory request valid
//   inst_addr_o      memory request address (the fetch PC)
//   inst_gnt_i       memory accepts the request this cycle
//   inst_rvalid_i    memory read data valid (in request order)
//   inst_rdata_i     memory read data (instruction word)
//   if_pc_o          PC of the head entry
//   if_inst_o        instruction of the head entry
//   if_valid_o       head entry is filled and presented
// ============================================================================
module if_fetch_unit #(
    parameter int                 ADDR_W     = 32,
    parameter int                 DATA_W     = 32,
    parameter int                 FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              inst_req_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_gnt_i,
    input  logic              inst_rvalid_i,
    input  logic [DATA_W-1:0] inst_rdata_i,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [DATA_W-1:0] if_inst_o,
    output logic              if_valid_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    // Control state (reset)
    logic [ADDR_W-1:0]     fetch_pc_p0;
    logic [PTR_W-1:0]      wr_ptr_p0;
    logic [PTR_W-1:0]      fill_ptr_p0;
    logic [PTR_W-1:0]      rd_ptr_p0;
    logic [CNT_W-1:0]      count_p0;
    logic [CNT_W-1:0]      pend_p0;
    logic [CNT_W-1:0]      drop_cnt_p0;
    logic [FIFO_DEPTH-1:0] filled_p0;

    // Entry payload (not reset; qualified by filled_p0)
    logic [ADDR_W-1:0]     pc_p0   [FIFO_DEPTH];
    logic [DATA_W-1:0]     inst_p0 [FIFO_DEPTH];

    logic                  pop;
    logic                  issue;
    logic                  credit;
    logic                  rsp_drop;
    logic                  rsp_fill;
    logic [SUM_W-1:0]      occupancy;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      redirect_drop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

    // Head presentation: payload is gated by the filled flag. The outputs
    // are therefore zero whenever nothing valid is at the head.
    assign if_valid_o = filled_p0[rd_ptr_p0];
    assign if_pc_o    = if_valid_o ? pc_p0[rd_ptr_p0]   : '0;
    assign if_inst_o  = if_valid_o ? inst_p0[rd_ptr_p0] : '0;

    assign pop = if_valid_o & ~stall_i & ~branch_flag_i;

    // A slot freed by this cycle's pop may be reused by this cycle's issue.
    // Without that reuse, a two-entry queue could not sustain one
    // instruction per cycle. Owed-but-dropped responses still hold credit.
    assign occupancy = SUM_W'(count_p0) + SUM_W'(drop_cnt_p0) - SUM_W'(pop);
    assign credit    = occupancy < SUM_W'(FIFO_DEPTH);

    assign inst_req_o  = ~rst & ~branch_flag_i & credit;
    assign inst_addr_o = fetch_pc_p0;
    assign issue       = inst_req_o & inst_gnt_i;

    // A response with nothing owed (no drops, no unfilled entry) is ignored.
    assign rsp_drop = inst_rvalid_i & (drop_cnt_p0 != '0);
    assign rsp_fill = inst_rvalid_i & (drop_cnt_p0 == '0) & (pend_p0 != '0);

    // On redirect, every unfilled entry turns into a response to drop.
    // A response arriving in the redirect cycle pays one of those off.
    assign outstanding   = drop_cnt_p0 + pend_p0;
    assign redirect_drop = outstanding - CNT_W'(inst_rvalid_i && (outstanding != '0));

    // ---- p0: fetch queue control ------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_p0 <= RESET_PC;
            wr_ptr_p0   <= '0;
            fill_ptr_p0 <= '0;
            rd_ptr_p0   <= '0;
            count_p0    <= '0;
            pend_p0     <= '0;
            drop_cnt_p0 <= '0;
            filled_p0   <= '0;
        end else if (branch_flag_i) begin
            fetch_pc_p0 <= branch_target_i & ~ADDR_W'(3);
            wr_ptr_p0   <= '0;
            fill_ptr_p0 <= '0;
            rd_ptr_p0   <= '0;
            count_p0    <= '0;
            pend_p0     <= '0;
            drop_cnt_p0 <= redirect_drop;
            filled_p0   <= '0;
        end else begin
            if (issue) begin
                fetch_pc_p0          <= fetch_pc_p0 + ADDR_W'(4);
                wr_ptr_p0            <= ptr_inc(wr_ptr_p0);
                filled_p0[wr_ptr_p0] <= 1'b0;
            end
            if (rsp_drop) begin
                drop_cnt_p0 <= drop_cnt_p0 - CNT_W'(1);
            end
            if (rsp_fill) begin
                filled_p0[fill_ptr_p0] <= 1'b1;
                fill_ptr_p0            <= ptr_inc(fill_ptr_p0);
            end
            if (pop) begin
                filled_p0[rd_ptr_p0] <= 1'b0;
                rd_ptr_p0            <= ptr_inc(rd_ptr_p0);
            end
            count_p0 <= count_p0 + CNT_W'(issue) - CNT_W'(pop);
            pend_p0  <= pend_p0 + CNT_W'(issue) - CNT_W'(rsp_fill);
        end
    end

    // ---- p0: fetch queue payload ------------------------------------------
    always_ff @(posedge clk) begin
        if (issue) begin
            pc_p0[wr_ptr_p0] <= fetch_pc_p0;
        end
        if (rsp_fill) begin
            inst_p0[fill_ptr_p0] <= inst_rdata_i;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 2;

    logic              clk;
    logic              rst;
    logic              stall_i;
    logic              branch_flag_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic              inst_req_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic              inst_gnt_i;
    logic              inst_rvalid_i;
    logic [DATA_W-1:0] inst_rdata_i;
    logic [ADDR_W-1:0] if_pc_o;
    logic [DATA_W-1:0] if_inst_o;
    logic              if_valid_o;

    if_fetch_unit #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .inst_req_o     (inst_req_o),
        .inst_addr_o    (inst_addr_o),
        .inst_gnt_i     (inst_gnt_i),
        .inst_rvalid_i  (inst_rvalid_i),
        .inst_rdata_i   (inst_rdata_i),
        .if_pc_o        (if_pc_o),
        .if_inst_o      (if_inst_o),
        .if_valid_o     (if_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        gnt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    mreq_t mq[$];
    vec_t  tq[$];
    int    lat;
    int    cyc;
    int    checks;
    int    errors;
    logic  force_rv;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic b, input logic [31:0] t, input logic g,
                       input logic er, input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.br = b; v.tgt = t; v.gnt = g;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        tq.push_back(v);
    endtask

    // One bus cycle: drive inputs at the falling edge, let combinational
    // outputs settle, then record any accepted request for the memory model.
    task automatic step(input logic s, input logic b, input logic [31:0] t, input logic g);
        logic        rv;
        logic        from_q;
        logic [31:0] rd;
        @(negedge clk);
        cyc    = cyc + 1;
        rv     = 1'b0;
        from_q = 1'b0;
        rd     = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rv     = 1'b1;
            from_q = 1'b1;
            rd     = inst_of(mq[0].addr);
        end else if (force_rv) begin
            rv = 1'b1;
            rd = 32'hBAD0_BAD0;
        end
        stall_i         = s;
        branch_flag_i   = b;
        branch_target_i = t;
        inst_gnt_i      = g;
        inst_rvalid_i   = rv;
        inst_rdata_i    = rd;
        #1;
        if (inst_req_o && inst_gnt_i) mq.push_back('{addr: inst_addr_o, due: cyc + lat});
        if (from_q) mq.delete(0);
    endtask

    task automatic chk_head(input string name, input logic ev, input logic [31:0] ep);
        chk({name, "_valid"}, {31'd0, if_valid_o}, {31'd0, ev});
        chk({name, "_pc"}, if_pc_o, ev ? ep : 32'h0);
        chk({name, "_inst"}, if_inst_o, ev ? inst_of(ep) : 32'h0);
    endtask

    task automatic chk_req(input string name, input logic er, input logic [31:0] ea);
        chk({name, "_req"}, {31'd0, inst_req_o}, {31'd0, er});
        chk({name, "_addr"}, inst_addr_o, ea);
    endtask

    task automatic drive_idle();
        stall_i         = 1'b0;
        branch_flag_i   = 1'b0;
        branch_target_i = '0;
        inst_gnt_i      = 1'b0;
        inst_rvalid_i   = 1'b0;
        inst_rdata_i    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        mq.delete();
        @(negedge clk);
        #1;
        chk_req("rst", 1'b0, 32'h0);
        chk_head("rst", 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc = -1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (int'(dut.count_p0) + int'(dut.drop_cnt_p0) > FIFO_DEPTH) begin
                errors++;
                $display("FAIL credit_invariant cyc=%0d count=%0d drop=%0d limit=%0d",
                         cyc, dut.count_p0, dut.drop_cnt_p0, FIFO_DEPTH);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        force_rv = 1'b0;
        cyc      = -1;
        lat      = 1;
        drive_idle();

        // Streaming, 5-cycle stall at head 0x8, then redirect under stall.
        //   stall br  tgt           gnt req addr          vld pc
        add(0, 0, 32'h0,  1, 1, 32'h00, 0, 32'h00);
        add(0, 0, 32'h0,  1, 1, 32'h04, 0, 32'h00);
        add(0, 0, 32'h0,  1, 1, 32'h08, 1, 32'h00);
        add(0, 0, 32'h0,  1, 1, 32'h0C, 1, 32'h04);
        add(1, 0, 32'h0,  1, 0, 32'h10, 1, 32'h08);
        add(1, 0, 32'h0,  1, 0, 32'h10, 1, 32'h08);
        add(1, 0, 32'h0,  1, 0, 32'h10, 1, 32'h08);
        add(1, 0, 32'h0,  1, 0, 32'h10, 1, 32'h08);
        add(1, 0, 32'h0,  1, 0, 32'h10, 1, 32'h08);
        add(0, 0, 32'h0,  1, 1, 32'h10, 1, 32'h08);
        add(0, 0, 32'h0,  1, 1, 32'h14, 1, 32'h0C);
        add(0, 0, 32'h0,  1, 1, 32'h18, 1, 32'h10);
        add(1, 1, 32'h40, 1, 0, 32'h1C, 1, 32'h14);
        add(0, 0, 32'h0,  1, 1, 32'h40, 0, 32'h00);
        add(0, 0, 32'h0,  1, 1, 32'h44, 0, 32'h00);
        add(0, 0, 32'h0,  1, 1, 32'h48, 1, 32'h40);

        lat = 1;
        do_reset();
        foreach (tq[i]) begin
            step(tq[i].stall, tq[i].br, tq[i].tgt, tq[i].gnt);
            chk_req($sformatf("tbl%0d", i), tq[i].exp_req, tq[i].exp_addr);
            chk_head($sformatf("tbl%0d", i), tq[i].exp_valid, tq[i].exp_pc);
        end

        // Asynchronous reset between edges while the head is valid.
        #2;
        rst = 1'b1;
        drive_idle();
        mq.delete();
        #1;
        chk_req("arst", 1'b0, 32'h0);
        chk_head("arst", 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc = -1;
        step(0, 0, 32'h0, 1); chk_req("arst_c0", 1'b1, 32'h00); chk_head("arst_c0", 1'b0, 32'h0);
        step(0, 0, 32'h0, 1); chk_req("arst_c1", 1'b1, 32'h04);
        step(0, 0, 32'h0, 1); chk_head("arst_c2", 1'b1, 32'h00);

        // Grant withheld for 4 cycles, plus a response nobody asked for.
        lat = 1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            force_rv = (i == 1);
            step(0, 0, 32'h0, 0);
            chk_req($sformatf("nognt%0d", i), 1'b1, 32'h00);
            chk_head($sformatf("nognt%0d", i), 1'b0, 32'h0);
        end
        force_rv = 1'b0;
        step(0, 0, 32'h0, 1); chk_req("gnt_c4", 1'b1, 32'h00);
        step(0, 0, 32'h0, 1); chk_req("gnt_c5", 1'b1, 32'h04); chk_head("gnt_c5", 1'b0, 32'h0);
        step(0, 0, 32'h0, 1); chk_req("gnt_c6", 1'b1, 32'h08); chk_head("gnt_c6", 1'b1, 32'h00);
        step(0, 0, 32'h0, 1); chk_head("gnt_c7", 1'b1, 32'h04);

        // Redirect to the top of the address space; fetch PC wraps to zero.
        lat = 1;
        do_reset();
        step(0, 1, 32'hFFFF_FFFF, 1); chk_req("wrap_c0", 1'b0, 32'h0);
        step(0, 0, 32'h0, 1); chk_req("wrap_c1", 1'b1, 32'hFFFF_FFFC);
        step(0, 0, 32'h0, 1); chk_req("wrap_c2", 1'b1, 32'h0000_0000);
        step(0, 0, 32'h0, 1); chk_head("wrap_c3", 1'b1, 32'hFFFF_FFFC);
        step(0, 0, 32'h0, 1); chk_head("wrap_c4", 1'b1, 32'h0000_0000);

        // Redirect with two requests in flight, 3-cycle memory latency.
        lat = 3;
        do_reset();
        step(0, 0, 32'h0, 1);   chk_req("rd3_c0", 1'b1, 32'h00);
        step(0, 0, 32'h0, 1);   chk_req("rd3_c1", 1'b1, 32'h04);
        step(0, 1, 32'h103, 1); chk_req("rd3_c2", 1'b0, 32'h08);
        step(0, 0, 32'h0, 1);   chk_req("rd3_c3", 1'b0, 32'h100);
        chk("rd3_drop2", 32'(dut.drop_cnt_p0), 32'd2);
        step(0, 0, 32'h0, 1);   chk_req("rd3_c4", 1'b1, 32'h100);
        step(0, 0, 32'h0, 1);   chk_req("rd3_c5", 1'b1, 32'h104);
        chk("rd3_drop0", 32'(dut.drop_cnt_p0), 32'd0);
        step(0, 0, 32'h0, 1);   chk_req("rd3_c6", 1'b0, 32'h108); chk_head("rd3_c6", 1'b0, 32'h0);
        step(0, 0, 32'h0, 1);   chk_head("rd3_c7", 1'b0, 32'h0);
        step(0, 0, 32'h0, 1);   chk_head("rd3_c8", 1'b1, 32'h100); chk_req("rd3_c8", 1'b1, 32'h108);
        step(0, 0, 32'h0, 1);   chk_head("rd3_c9", 1'b1, 32'h104);

        // Redirect in the same cycle as a response, one other entry unfilled.
        lat = 2;
        do_reset();
        step(0, 0, 32'h0, 1);   chk_req("rd2_c0", 1'b1, 32'h00);
        step(0, 0, 32'h0, 1);   chk_req("rd2_c1", 1'b1, 32'h04);
        step(0, 1, 32'h200, 1); chk("rd2_rv", {31'd0, inst_rvalid_i}, 32'd1);
        step(0, 0, 32'h0, 1);   chk_req("rd2_c3", 1'b1, 32'h200);
        chk("rd2_drop1", 32'(dut.drop_cnt_p0), 32'd1);
        step(0, 0, 32'h0, 1);   chk_req("rd2_c4", 1'b1, 32'h204);
        step(0, 0, 32'h0, 1);   chk_req("rd2_c5", 1'b0, 32'h208); chk_head("rd2_c5", 1'b0, 32'h0);
        step(0, 0, 32'h0, 1);   chk_head("rd2_c6", 1'b1, 32'h200);
        step(0, 0, 32'h0, 1);   chk_head("rd2_c7", 1'b1, 32'h204);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues in-order requests to instruction memory over a request/grant/response handshake.
- Holds up to FIFO_DEPTH fetched-or-in-flight entries and presents {pc, inst, valid} to IF/ID.
- Handles downstream stall and branch redirect, including discarding stale in-flight responses.

Parameters:
- ADDR_W, 32, instruction address width.
- DATA_W, 32, instruction word width.
- FIFO_DEPTH, 2, maximum entries (in-flight plus fetched-not-consumed); power of two, ≥2.
- RESET_PC, 32'h00000000, fetch PC after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  IF/ID cannot accept this cycle; head entry held.
- branch_flag_i  in  1  one-cycle redirect request from ID.
- branch_target_i  in  ADDR_W  redirect target; bits [1:0] ignored (forced 00).
- inst_req_o  out  1  memory request valid.
- inst_addr_o  out  ADDR_W  request address (= fetch_pc).
- inst_gnt_i  in  1  memory accepts request this cycle (meaningful only with inst_req_o).
- inst_rvalid_i  in  1  read data valid; responses return in request order, latency ≥1.
- inst_rdata_i  in  DATA_W  instruction word.
- if_pc_o  out  ADDR_W  PC of head entry to IF/ID.
- if_inst_o  out  DATA_W  instruction of head entry.
- if_valid_o  out  1  head entry filled and presented.

Behaviour:
- Reset (async, immediate):
  - fetch_pc=RESET_PC; queue empty; drop_cnt=0.
  - inst_req_o=0, if_valid_o=0, if_pc_o=0, if_inst_o=0.
  - Pre-reset in-flight responses are the environment's responsibility.
- Queue:
  - Circular buffer of FIFO_DEPTH entries {pc, inst, filled}, with wr_ptr, fill_ptr, rd_ptr and count.
  - count includes unfilled (in-flight) entries.
- pop = if_valid_o & ~stall_i & ~branch_flag_i.
- Credit: inst_req_o = ~branch_flag_i & (count + drop_cnt − pop < FIFO_DEPTH). Combinational from stall_i is permitted.
- Issue (inst_req_o & inst_gnt_i):
  - Allocate the entry at wr_ptr with pc=fetch_pc, filled=0.
  - fetch_pc += 4; fetch_pc wraps modulo 2^ADDR_W.
  - inst_addr_o must stay stable while inst_req_o=1 and not granted.
- Response (inst_rvalid_i):
  - If drop_cnt>0: decrement drop_cnt and discard the data.
  - Else: write inst into entry at fill_ptr, set filled, advance fill_ptr.
  - A response with no outstanding request is ignored.
- Output:
  - if_valid_o = head.filled. if_pc_o/if_inst_o = head fields when valid, else 0.
  - Outputs are driven from registers; no combinational path from inst_rdata_i.
- Latency: with a zero-wait grant and 1-cycle rvalid, a request issued in cycle N appears on if_valid_o in cycle N+2.
- Throughput: with FIFO_DEPTH≥2 and no stall, sustained 1 instruction/cycle.
- Stall: head and all outputs held unchanged. Issue continues while credit remains. Responses still fill entries.
- Redirect (branch_flag_i=1):
  - No issue and no pop this cycle.
  - Next edge: fetch_pc=target & ~3; queue cleared (count=0, pointers=0, if_valid_o=0).
  - drop_cnt_next = drop_cnt + unfilled_count − inst_rvalid_i. A same-cycle response is absorbed into the drop accounting.
  - Fetching from the target resumes the following cycle, subject to credit.
- Redirect while stall_i=1: redirect wins; the held entry is discarded.
- Back-to-back redirects: the latest target wins; drop_cnt accumulates correctly.
- Simultaneous issue + response + pop in one cycle is legal; count updates by +1 −1 as applicable.
- Invariant: count + drop_cnt ≤ FIFO_DEPTH at all times (assert in bench).

Test Plan:
- Reset release, memory grant=1 and rvalid 1 cycle later, stall_i=0 → addresses 0,4,8,… issued every cycle. if_valid_o first high 2 cycles after the first request. if_pc_o sequence 0,4,8 with matching rdata.
- Hold stall_i=1 for 5 cycles mid-stream with head pc=0x8 → if_pc_o=0x8 constant. inst_req_o drops once count=2. On release, 0xC follows next cycle with no duplicate or loss.
- Redirect to 0x103 with 2 requests in flight under 3-cycle memory latency → next inst_addr_o=0x100. The two stale responses are discarded (drop_cnt 2→0). First if_pc_o after redirect = 0x100.
- Redirect in the same cycle as an rvalid for an in-flight entry, with one other unfilled entry → drop_cnt=1. Only one later response is dropped; the target instruction is delivered.
- Grant withheld for 4 cycles with inst_req_o high → inst_addr_o stable, fetch_pc unchanged. Issue proceeds on the first grant.
- Assert rst asynchronously mid-stream (between edges) → all outputs 0 immediately. After release, fetch restarts at RESET_PC=0x0.
